// File: rtl/axi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : axi_ram_ctrl
//  Purpose  : AXI4 slave front-end for a single-port behavioural RAM. Converts
//             AXI4 read and write bursts into single-beat RAM accesses (word
//             address, write enable, read enable, byte strobes, write data).
//             RAM read data returns one cycle after the read enable. Only one
//             burst is serviced at a time.
//  Ports    : clk, rst (sync, active-high)
//             AW : i_awid/i_awaddr/i_awlen/i_awsize/i_awburst, i_awvalid, o_awready
//             W  : i_wdata/i_wstrb/i_wlast, i_wvalid, o_wready
//             B  : o_bid, o_bresp, o_bvalid, i_bready
//             AR : i_arid/i_araddr/i_arlen/i_arsize/i_arburst, i_arvalid, o_arready
//             R  : o_rid, o_rdata, o_rresp, o_rlast, o_rvalid, i_rready
//             RAM: o_ram_addr, o_ram_wr_en, o_ram_rd_en, o_ram_strobe,
//                  o_ram_w_data, i_ram_r_data
//  Config   : AXI_RAM_WRAP_BURST_EN - when defined, WRAP bursts wrap inside
//             their aligned window; otherwise WRAP behaves as INCR.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_ram_ctrl #(
    parameter int DATA_WD = 128,
    parameter int ADDR_WD = 32,
    parameter int ID_WD   = 4,
    parameter int STRB_WD = DATA_WD / 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ID_WD-1:0]   i_awid,
    input  logic [ADDR_WD-1:0] i_awaddr,
    input  logic [7:0]         i_awlen,
    input  logic [2:0]         i_awsize,
    input  logic [1:0]         i_awburst,
    input  logic               i_awvalid,
    output logic               o_awready,
    input  logic [DATA_WD-1:0] i_wdata,
    input  logic [STRB_WD-1:0] i_wstrb,
    input  logic               i_wlast,
    input  logic               i_wvalid,
    output logic               o_wready,
    output logic [ID_WD-1:0]   o_bid,
    output logic [1:0]         o_bresp,
    output logic               o_bvalid,
    input  logic               i_bready,
    input  logic [ID_WD-1:0]   i_arid,
    input  logic [ADDR_WD-1:0] i_araddr,
    input  logic [7:0]         i_arlen,
    input  logic [2:0]         i_arsize,
    input  logic [1:0]         i_arburst,
    input  logic               i_arvalid,
    output logic               o_arready,
    output logic [ID_WD-1:0]   o_rid,
    output logic [DATA_WD-1:0] o_rdata,
    output logic [1:0]         o_rresp,
    output logic               o_rlast,
    output logic               o_rvalid,
    input  logic               i_rready,
    output logic [ADDR_WD-1:0] o_ram_addr,
    output logic               o_ram_wr_en,
    output logic               o_ram_rd_en,
    output logic [STRB_WD-1:0] o_ram_strobe,
    output logic [DATA_WD-1:0] o_ram_w_data,
    input  logic [DATA_WD-1:0] i_ram_r_data
);

    localparam int ADDR_LSB = $clog2(STRB_WD);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_CAP  = 3'd4,
        S_RD_RESP = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_WD-1:0]     r_id;
    logic [ADDR_WD-1:0]   r_addr;
    logic [7:0]           r_len;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [7:0]           r_beat;
    logic                 r_rr_last_rd;
    logic                 r_werr;
    logic [DATA_WD-1:0]   r_rdata;

    logic                 w_aw_grant;
    logic                 w_ar_grant;
    logic                 w_last_beat;
    logic [ADDR_WD-1:0]   w_incr;
    logic [ADDR_WD-1:0]   w_addr_inc;
    logic [ADDR_WD-1:0]   w_next_addr;

    // On a simultaneous request the channel not served last time wins.
    assign w_aw_grant  = i_awvalid & (~i_arvalid | r_rr_last_rd);
    assign w_ar_grant  = i_arvalid & ~w_aw_grant;
    assign w_last_beat = (r_beat == r_len);

    assign w_incr     = ADDR_WD'(1) << r_size;
    assign w_addr_inc = r_addr + w_incr;

`ifdef AXI_RAM_WRAP_BURST_EN
    logic [ADDR_WD-1:0] w_wrap_mask;
    assign w_wrap_mask = ((ADDR_WD'(r_len) + ADDR_WD'(1)) << r_size) - ADDR_WD'(1);
`endif

    always_comb begin
        w_next_addr = w_addr_inc;
        case (r_burst)
            2'b00:   w_next_addr = r_addr;
`ifdef AXI_RAM_WRAP_BURST_EN
            2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_addr_inc & w_wrap_mask);
`endif
            default: w_next_addr = w_addr_inc;
        endcase
    end

    // Narrow beats naturally reuse a word until the byte address crosses it.
    assign o_ram_addr = r_addr >> ADDR_LSB;
    assign o_bid      = r_id;
    assign o_rid      = r_id;
    assign o_rdata    = r_rdata;
    assign o_rresp    = 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_awready    = 1'b0;
        o_arready    = 1'b0;
        o_wready     = 1'b0;
        o_bvalid     = 1'b0;
        o_bresp      = 2'b00;
        o_rvalid     = 1'b0;
        o_rlast      = 1'b0;
        o_ram_wr_en  = 1'b0;
        o_ram_rd_en  = 1'b0;
        o_ram_strobe = '0;
        o_ram_w_data = '0;
        case (r_state)
            S_IDLE: begin
                o_awready = w_aw_grant;
                o_arready = w_ar_grant;
                if (w_aw_grant) begin
                    w_state_nxt = S_WR_DATA;
                end else if (w_ar_grant) begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_WR_DATA: begin
                o_wready = 1'b1;
                if (i_wvalid) begin
                    o_ram_wr_en  = 1'b1;
                    o_ram_strobe = i_wstrb;
                    o_ram_w_data = i_wdata;
                    if (w_last_beat) begin
                        w_state_nxt = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                o_bvalid = 1'b1;
                o_bresp  = r_werr ? 2'b10 : 2'b00;
                if (i_bready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ: begin
                o_ram_rd_en = 1'b1;
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_state_nxt = S_RD_RESP;
            end
            S_RD_RESP: begin
                o_rvalid = 1'b1;
                o_rlast  = w_last_beat;
                if (i_rready) begin
                    w_state_nxt = w_last_beat ? S_IDLE : S_RD_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id         <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_beat       <= '0;
            r_rr_last_rd <= 1'b1;
            r_werr       <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_grant) begin
                        r_id         <= i_awid;
                        r_addr       <= i_awaddr;
                        r_len        <= i_awlen;
                        r_size       <= i_awsize;
                        r_burst      <= i_awburst;
                        r_beat       <= '0;
                        r_werr       <= 1'b0;
                        r_rr_last_rd <= 1'b0;
                    end else if (w_ar_grant) begin
                        r_id         <= i_arid;
                        r_addr       <= i_araddr;
                        r_len        <= i_arlen;
                        r_size       <= i_arsize;
                        r_burst      <= i_arburst;
                        r_beat       <= '0;
                        r_rr_last_rd <= 1'b1;
                    end
                end
                S_WR_DATA: begin
                    if (i_wvalid) begin
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_next_addr;
                        // wlast must match the beat count exactly; any mismatch flags SLVERR.
                        r_werr <= r_werr | (w_last_beat ? ~i_wlast : i_wlast);
                    end
                end
                S_RD_CAP: begin
                    r_rdata <= i_ram_r_data;
                end
                S_RD_RESP: begin
                    if (i_rready && !w_last_beat) begin
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_next_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_ram_ctrl
//  Purpose  : Self-checking bench for axi_ram_ctrl with a behavioural RAM and
//             an address/data reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ram_ctrl;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic          clk;
    logic          rst;
    logic [IW-1:0] i_awid, i_arid;
    logic [AW-1:0] i_awaddr, i_araddr;
    logic [7:0]    i_awlen, i_arlen;
    logic [2:0]    i_awsize, i_arsize;
    logic [1:0]    i_awburst, i_arburst;
    logic          i_awvalid, i_arvalid, i_wvalid, i_wlast, i_bready, i_rready;
    logic [DW-1:0] i_wdata, i_ram_r_data;
    logic [SW-1:0] i_wstrb;
    logic          o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_rlast;
    logic [IW-1:0] o_bid, o_rid;
    logic [1:0]    o_bresp, o_rresp;
    logic [DW-1:0] o_rdata, o_ram_w_data;
    logic [AW-1:0] o_ram_addr;
    logic          o_ram_wr_en, o_ram_rd_en;
    logic [SW-1:0] o_ram_strobe;

    axi_ram_ctrl #(.DATA_WD(DW), .ADDR_WD(AW), .ID_WD(IW), .STRB_WD(SW)) u_dut (
        .clk(clk), .rst(rst),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_ram_addr(o_ram_addr), .o_ram_wr_en(o_ram_wr_en), .o_ram_rd_en(o_ram_rd_en),
        .o_ram_strobe(o_ram_strobe), .o_ram_w_data(o_ram_w_data), .i_ram_r_data(i_ram_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural RAM (driven by the DUT) and reference memory (driven by the bench).
    logic [DW-1:0] ram_mem [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (o_ram_wr_en) ram_mem[o_ram_addr[11:0]] <= merge(ram_mem[o_ram_addr[11:0]], o_ram_w_data, o_ram_strobe);
        i_ram_r_data <= o_ram_rd_en ? ram_mem[o_ram_addr[11:0]] : {$urandom, $urandom, $urandom, $urandom};
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("wr_rd_exclusive", {127'd0, o_ram_wr_en & o_ram_rd_en}, '0);
            check_eq("rd_en_while_rvalid", {127'd0, o_ram_rd_en & o_rvalid}, '0);
        end
    end

    // Byte address of beat i, computed in closed form from the burst rules.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int len,
                                                input int size, input int burst, input int i);
        logic [AW-1:0] incr;
        logic [AW-1:0] mask;
        incr = 32'd1 << size;
        mask = '0;
        if (burst == 0) return a;
`ifdef AXI_RAM_WRAP_BURST_EN
        if (burst == 2) begin
            mask = 32'(len + 1) * incr - 32'd1;
            return (a & ~mask) | ((a + 32'(i) * incr) & mask);
        end
`endif
        return a + 32'(i) * incr;
    endfunction

    task automatic aw_phase(input int id, input logic [AW-1:0] a, input int len, input int size, input int burst);
        int n;
        i_awid = IW'(id); i_awaddr = a; i_awlen = 8'(len); i_awsize = 3'(size);
        i_awburst = 2'(burst); i_awvalid = 1'b1;
        #1;
        n = 0;
        while (!o_awready && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("awready", {127'd0, o_awready}, 1);
        @(negedge clk);
        i_awvalid = 1'b0;
    endtask

    task automatic ar_phase(input int id, input logic [AW-1:0] a, input int len, input int size, input int burst);
        int n;
        i_arid = IW'(id); i_araddr = a; i_arlen = 8'(len); i_arsize = 3'(size);
        i_arburst = 2'(burst); i_arvalid = 1'b1;
        #1;
        n = 0;
        while (!o_arready && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("arready", {127'd0, o_arready}, 1);
        @(negedge clk);
        i_arvalid = 1'b0;
    endtask

    // strb_mode: 0 full, 1 random, 2 upper-half then lower-half. bad_last: wlast wrong every beat.
    task automatic w_phase(input logic [AW-1:0] a, input int len, input int size, input int burst,
                           input int strb_mode, input bit bad_last);
        logic [AW-1:0] word;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_wvalid = 1'b0;
                #1;
                check_eq("wr_en_idle_gap", {127'd0, o_ram_wr_en}, 0);
                @(negedge clk);
            end
            word = beat_addr(a, len, size, burst, i) >> 4;
            i_wdata  = {$urandom, $urandom, $urandom, $urandom};
            i_wstrb  = (strb_mode == 0) ? 16'hFFFF :
                       (strb_mode == 1) ? 16'($urandom) : ((i == 0) ? 16'hFF00 : 16'h00FF);
            i_wlast  = bad_last ? (i != len) : (i == len);
            i_wvalid = 1'b1;
            #1;
            check_eq("wready", {127'd0, o_wready}, 1);
            check_eq("ram_wr_en", {127'd0, o_ram_wr_en}, 1);
            check_eq("ram_wr_addr", {96'd0, o_ram_addr}, {96'd0, word});
            check_eq("ram_strobe", {112'd0, o_ram_strobe}, {112'd0, i_wstrb});
            check_eq("ram_w_data", o_ram_w_data, i_wdata);
            ref_mem[word[11:0]] = merge(ref_mem[word[11:0]], i_wdata, i_wstrb);
            @(negedge clk);
        end
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
    endtask

    task automatic b_phase(input int id, input int resp);
        int n;
        int dly;
        dly = $urandom_range(0, 3);
        #1;
        n = 0;
        while (!o_bvalid && n < 50) begin @(negedge clk); #1; n++; end
        check_eq("bvalid", {127'd0, o_bvalid}, 1);
        repeat (dly) begin
            @(negedge clk); #1;
            check_eq("bvalid_held", {127'd0, o_bvalid}, 1);
        end
        i_bready = 1'b1;
        #1;
        check_eq("bid", {124'd0, o_bid}, 128'(id));
        check_eq("bresp", {126'd0, o_bresp}, 128'(resp));
        @(negedge clk);
        i_bready = 1'b0;
    endtask

    task automatic r_phase(input int id, input logic [AW-1:0] a, input int len, input int size,
                           input int burst, input int stall);
        logic [AW-1:0] word;
        logic [DW-1:0] held;
        int n;
        bit seen_rd;
        for (int i = 0; i <= len; i++) begin
            word = beat_addr(a, len, size, burst, i) >> 4;
            #1;
            n = 0;
            seen_rd = 0;
            while (!o_rvalid && n < 50) begin
                if (o_ram_rd_en) begin
                    seen_rd = 1;
                    check_eq("ram_rd_addr", {96'd0, o_ram_addr}, {96'd0, word});
                end
                @(negedge clk); #1; n++;
            end
            check_eq("rd_en_seen", {127'd0, seen_rd}, 1);
            check_eq("rvalid", {127'd0, o_rvalid}, 1);
            check_eq("rid", {124'd0, o_rid}, 128'(id));
            check_eq("rdata", o_rdata, ref_mem[word[11:0]]);
            check_eq("rresp", {126'd0, o_rresp}, 0);
            check_eq("rlast", {127'd0, o_rlast}, {127'd0, (i == len)});
            held = o_rdata;
            repeat (stall) begin
                @(negedge clk); #1;
                check_eq("rvalid_stall", {127'd0, o_rvalid}, 1);
                check_eq("rdata_stall", o_rdata, held);
                check_eq("rd_en_stall", {127'd0, o_ram_rd_en}, 0);
            end
            i_rready = 1'b1;
            @(negedge clk);
            i_rready = 1'b0;
        end
    endtask

    task automatic do_write(input int id, input logic [AW-1:0] a, input int len, input int size,
                            input int burst, input int strb_mode, input bit bad_last);
        aw_phase(id, a, len, size, burst);
        w_phase(a, len, size, burst, strb_mode, bad_last);
        b_phase(id, bad_last ? 2 : 0);
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] a, input int len, input int size,
                           input int burst, input int stall);
        ar_phase(id, a, len, size, burst);
        r_phase(id, a, len, size, burst, stall);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_awready"}, {127'd0, o_awready}, 0);
        check_eq({tag, "_arready"}, {127'd0, o_arready}, 0);
        check_eq({tag, "_wready"},  {127'd0, o_wready}, 0);
        check_eq({tag, "_bvalid"},  {127'd0, o_bvalid}, 0);
        check_eq({tag, "_rvalid"},  {127'd0, o_rvalid}, 0);
        check_eq({tag, "_rlast"},   {127'd0, o_rlast}, 0);
        check_eq({tag, "_wr_en"},   {127'd0, o_ram_wr_en}, 0);
        check_eq({tag, "_rd_en"},   {127'd0, o_ram_rd_en}, 0);
        check_eq({tag, "_bresp"},   {126'd0, o_bresp}, 0);
        check_eq({tag, "_ram_addr"}, {96'd0, o_ram_addr}, 0);
        check_eq({tag, "_bid"},     {124'd0, o_bid}, 0);
        check_eq({tag, "_rid"},     {124'd0, o_rid}, 0);
        check_eq({tag, "_rdata"},   o_rdata, 0);
    endtask

    initial begin
        int burst, size, len, id, addr_off;
        logic [DW-1:0] d;
        for (int k = 0; k < 4096; k++) begin ram_mem[k] = '0; ref_mem[k] = '0; end
        rst = 1'b1;
        i_awid = '0; i_awaddr = '0; i_awlen = '0; i_awsize = '0; i_awburst = '0; i_awvalid = 1'b0;
        i_arid = '0; i_araddr = '0; i_arlen = '0; i_arsize = '0; i_arburst = '0; i_arvalid = 1'b0;
        i_wdata = '0; i_wstrb = '0; i_wlast = 1'b0; i_wvalid = 1'b0; i_bready = 1'b0; i_rready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Simultaneous AW/AR right after reset: write first, then read.
        rst = 1'b0;
        i_arid = 4'd2; i_araddr = 32'h3000; i_arlen = 8'd0; i_arsize = 3'd4; i_arburst = 2'd1;
        i_arvalid = 1'b1;
        i_awid = 4'd1; i_awaddr = 32'h3000; i_awlen = 8'd0; i_awsize = 3'd4; i_awburst = 2'd1;
        i_awvalid = 1'b1;
        #1;
        check_eq("conflict1_awready", {127'd0, o_awready}, 1);
        check_eq("conflict1_arready", {127'd0, o_arready}, 0);
        aw_phase(1, 32'h3000, 0, 4, 1);
        #1;
        check_eq("arready_busy", {127'd0, o_arready}, 0);
        @(negedge clk);
        w_phase(32'h3000, 0, 4, 1, 0, 1'b0);
        b_phase(1, 0);
        i_awvalid = 1'b1;
        #1;
        check_eq("conflict2_arready", {127'd0, o_arready}, 1);
        check_eq("conflict2_awready", {127'd0, o_awready}, 0);
        i_awvalid = 1'b0;
        ar_phase(2, 32'h3000, 0, 4, 1);
        r_phase(2, 32'h3000, 0, 4, 1, 0);

        // Full-width INCR write then read back, with rready stalls.
        do_write(3, 32'h1000, 3, 4, 1, 0, 1'b0);
        do_read(5, 32'h1000, 3, 4, 1, 0);
        do_read(5, 32'h1000, 3, 4, 1, 5);

        // Narrow beats on an unaligned start.
        do_write(4, 32'h2008, 1, 3, 1, 2, 1'b0);
        do_read(6, 32'h2000, 1, 4, 1, 1);

        // WRAP burst (INCR behaviour when wrap support is compiled out).
        do_write(7, 32'h1030, 3, 4, 2, 1, 1'b0);
        do_read(8, 32'h1030, 3, 4, 2, 0);

        // Bad wlast yields SLVERR but data still lands.
        do_write(9, 32'h2100, 2, 4, 1, 0, 1'b1);
        do_read(9, 32'h2100, 2, 4, 1, 0);

        // Reset during beat 2 of a 4-beat write.
        aw_phase(10, 32'h4000, 3, 4, 1);
        d = {$urandom, $urandom, $urandom, $urandom};
        i_wdata = d; i_wstrb = 16'hFFFF; i_wlast = 1'b0; i_wvalid = 1'b1;
        ref_mem[12'h400] = d;
        @(negedge clk);
        i_wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (5) begin
            @(negedge clk); #1;
            check_eq("no_b_after_reset", {127'd0, o_bvalid}, 0);
        end
        @(negedge clk);
        do_write(11, 32'h4010, 1, 4, 1, 0, 1'b0);
        do_read(12, 32'h4000, 2, 4, 1, 0);

        // Randomized mixed traffic.
        for (int t = 0; t < 40; t++) begin
            burst = $urandom_range(0, 3);
            size  = $urandom_range(0, 4);
            len   = $urandom_range(0, 7);
`ifdef AXI_RAM_WRAP_BURST_EN
            if (burst == 2) len = (2 << $urandom_range(0, 2)) - 1;
`endif
            id       = $urandom_range(0, 15);
            addr_off = $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 0)
                do_write(id, 32'h8000 + (32'(addr_off) << size), len, size, burst, 1,
                         ($urandom_range(0, 5) == 0));
            else
                do_read(id, 32'h8000 + (32'(addr_off) << size), len, size, burst,
                        $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
